arcade_input_mapper: RTL and testbench

Generalised, parametrised input front-end for arcade cores. It merges the PS/2 keyboard with up to 4 MiSTer joysticks, applies 0/90/180/270° control rotation for rotated-screen play, and generates timed coin pulses and optional autofire. The result is one registered control byte per player, driven straight into the core's IN0/IN1-style input registers.

---
 rtl/arcade_input_mapper_if.sv | 23 ++
 rtl/arcade_input_mapper.sv | 163 ++++++++++++++++
 tb/tb_arcade_input_mapper.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/arcade_input_mapper_if.sv
// Control bundle between the arcade input mapper and its host: tick enable,
// keyboard/joystick/rotation inputs, per-player control bytes and coin status.
interface arcade_input_mapper_if #(
    parameter int PLAYERS = 2
);
    logic                  ce;
    logic [10:0]           ps2_key;
    logic [16*PLAYERS-1:0] joy_flat;
    logic [1:0]            rotate;
    logic                  autofire_en;
    logic [8*PLAYERS-1:0]  p_out;
    logic                  coin_busy;

    modport master (
        output ce, ps2_key, joy_flat, rotate, autofire_en,
        input  p_out, coin_busy
    );

    modport slave (
        input  ce, ps2_key, joy_flat, rotate, autofire_en,
        output p_out, coin_busy
    );
endinterface

// File: rtl/arcade_input_mapper.sv
// Keyboard + joystick merge, control rotation, coin pulse and autofire per player.
// Optional macro ARCADE_INPUT_SOCD_EN neutralises opposing directions after rotation.
module arcade_input_mapper #(
    parameter int PLAYERS      = 2,
    parameter int COIN_PULSE   = 16,
    parameter int AUTOFIRE_DIV = 4096,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                 clk_sys,
    input  logic                 RESET,
    arcade_input_mapper_if.slave bus
);
    localparam logic [7:0]  OUT_IDLE  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [15:0] COIN_LOAD = 16'(COIN_PULSE);
    localparam logic [15:0] AF_LAST   = 16'(AUTOFIRE_DIV - 1);

    logic               toggle_q;
    logic               primed_q;
    logic               key_evt;
    logic               key_pressed;
    logic [8:0]         key_code;
    logic [7:0]         kb0_q, kb0_d;   // player 0 keys, joystick bit order
    logic [1:0]         kb1_q, kb1_d;   // player 1 keys: {coin, start}
    logic [PLAYERS-1:0] coin_active;
    logic               unused_joy;

    assign key_pressed = bus.ps2_key[9];
    assign key_code    = bus.ps2_key[8:0];
    assign key_evt     = primed_q && (bus.ps2_key[10] != toggle_q);
    assign unused_joy  = ^bus.joy_flat;

    // First clock after reset only primes the toggle copy, never decodes.
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            toggle_q <= 1'b0;
            primed_q <= 1'b0;
            kb0_q    <= '0;
            kb1_q    <= '0;
        end else begin
            toggle_q <= bus.ps2_key[10];
            primed_q <= 1'b1;
            kb0_q    <= kb0_d;
            kb1_q    <= kb1_d;
        end
    end

    always_comb begin
        kb0_d = kb0_q;
        kb1_d = kb1_q;
        if (key_evt) begin
            case (key_code)
                9'h175:         kb0_d[3] = key_pressed;
                9'h172:         kb0_d[2] = key_pressed;
                9'h16B:         kb0_d[1] = key_pressed;
                9'h174:         kb0_d[0] = key_pressed;
                9'h029, 9'h014: kb0_d[4] = key_pressed;
                9'h011:         kb0_d[7] = key_pressed;
                9'h005:         kb0_d[5] = key_pressed;
                9'h02E:         kb0_d[6] = key_pressed;
                9'h006:         kb1_d[0] = key_pressed;
                9'h036:         kb1_d[1] = key_pressed;
                default:        ;
            endcase
        end
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic [7:0]  joy, kbd, raw, act, out_q;
        logic        up, dn, lf, rt, fire1;
        logic        af_active, af_phase_q, af_phase_d;
        logic [15:0] af_cnt_q, af_cnt_d;
        logic        coin_edge, coin_prev_q;
        logic [15:0] coin_cnt_q, coin_cnt_d;

        assign joy = bus.joy_flat[16*p +: 8];

        // Next-state key flags keep keyboard latency equal to joystick latency.
        if (p == 0) begin : g_kbd0
            assign kbd = kb0_d;
        end else if (p == 1) begin : g_kbd1
            assign kbd = {1'b0, kb1_d[1], kb1_d[0], 5'b0};
        end else begin : g_kbd_none
            assign kbd = '0;
        end

        assign raw = joy | kbd;

        always_comb begin
            {up, dn, lf, rt} = {raw[3], raw[2], raw[1], raw[0]};
            case (bus.rotate)
                2'd1:    {up, dn, lf, rt} = {raw[1], raw[0], raw[2], raw[3]};
                2'd2:    {up, dn, lf, rt} = {raw[2], raw[3], raw[0], raw[1]};
                2'd3:    {up, dn, lf, rt} = {raw[0], raw[1], raw[3], raw[2]};
                default: ;
            endcase
`ifdef ARCADE_INPUT_SOCD_EN
            if (up && dn) begin
                up = 1'b0;
                dn = 1'b0;
            end
            if (lf && rt) begin
                lf = 1'b0;
                rt = 1'b0;
            end
`endif
        end

        assign af_active = bus.autofire_en && raw[4];

        always_comb begin
            af_cnt_d   = af_cnt_q;
            af_phase_d = af_phase_q;
            if (!af_active) begin
                af_cnt_d   = '0;
                af_phase_d = 1'b0;
            end else if (bus.ce) begin
                if (af_cnt_q == AF_LAST) begin
                    af_cnt_d   = '0;
                    af_phase_d = ~af_phase_q;
                end else begin
                    af_cnt_d = af_cnt_q + 16'd1;
                end
            end
        end

        // Phase 0 is the asserted half, so a fresh press fires immediately.
        assign fire1 = af_active ? ~af_phase_q : raw[4];

        assign coin_edge = primed_q && raw[6] && !coin_prev_q;

        always_comb begin
            coin_cnt_d = coin_cnt_q;
            if (coin_edge && (coin_cnt_q == 16'd0)) begin
                coin_cnt_d = COIN_LOAD;
            end else if (bus.ce && (coin_cnt_q != 16'd0)) begin
                coin_cnt_d = coin_cnt_q - 16'd1;
            end
        end

        assign act = {(coin_cnt_d != 16'd0), raw[5], raw[7], fire1, rt, lf, dn, up};

        always_ff @(posedge clk_sys or posedge RESET) begin
            if (RESET) begin
                af_cnt_q    <= '0;
                af_phase_q  <= 1'b0;
                coin_cnt_q  <= '0;
                coin_prev_q <= 1'b0;
                out_q       <= OUT_IDLE;
            end else begin
                af_cnt_q    <= af_cnt_d;
                af_phase_q  <= af_phase_d;
                coin_cnt_q  <= coin_cnt_d;
                coin_prev_q <= raw[6];
                out_q       <= (ACTIVE_LOW != 0) ? ~act : act;
            end
        end

        assign bus.p_out[8*p +: 8] = out_q;
        assign coin_active[p]      = (coin_cnt_q != 16'd0);
    end

    assign bus.coin_busy = |coin_active;
endmodule

// File: tb/tb_arcade_input_mapper.sv
// Randomised and directed bench for arcade_input_mapper against a behavioural model
// (PLAYERS=2, COIN_PULSE=16, AUTOFIRE_DIV=4, ACTIVE_LOW=1).
module tb_arcade_input_mapper;
    localparam int P          = 2;
    localparam int COIN_PULSE = 16;
    localparam int AF_DIV     = 4;
    localparam int ACTIVE_LOW = 1;

    logic clk_sys = 1'b0;
    logic RESET   = 1'b1;

    arcade_input_mapper_if #(.PLAYERS(P)) bus ();

    arcade_input_mapper #(
        .PLAYERS      (P),
        .COIN_PULSE   (COIN_PULSE),
        .AUTOFIRE_DIV (AF_DIV),
        .ACTIVE_LOW   (ACTIVE_LOW)
    ) dut (
        .clk_sys (clk_sys),
        .RESET   (RESET),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: key flags in output-bit order (up,down,left,right,fire1,fire2,start,coin).
    int          kb [P][8];
    int          coin_rem [P];
    bit          coin_prev [P];
    int          af_ticks [P];
    bit          m_primed;
    bit          m_toggle;
    int          joybit [8] = '{3, 2, 1, 0, 4, 7, 5, 6};
    logic [15:0] exp_pout;
    logic        exp_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < P; p++) begin
            for (int f = 0; f < 8; f++) kb[p][f] = 0;
            coin_rem[p]  = 0;
            coin_prev[p] = 1'b0;
            af_ticks[p]  = 0;
        end
        m_primed = 1'b0;
        m_toggle = 1'b0;
        exp_pout = 16'hFFFF;
        exp_busy = 1'b0;
    endtask

    task automatic model_key(input logic [8:0] code, input bit pr);
        case (code)
            9'h175:         kb[0][0] = pr;
            9'h172:         kb[0][1] = pr;
            9'h16B:         kb[0][2] = pr;
            9'h174:         kb[0][3] = pr;
            9'h029, 9'h014: kb[0][4] = pr;
            9'h011:         kb[0][5] = pr;
            9'h005:         kb[0][6] = pr;
            9'h02E:         kb[0][7] = pr;
            9'h006:         kb[1][6] = pr;
            9'h036:         kb[1][7] = pr;
            default:        ;
        endcase
    endtask

    task automatic model_step();
        bit         raw [8];
        bit         cw [4];
        bit         rd [4];
        bit         o [8];
        logic [7:0] byte_v;
        if (m_primed && (bus.ps2_key[10] != m_toggle))
            model_key(bus.ps2_key[8:0], bus.ps2_key[9]);
        m_toggle = bus.ps2_key[10];
        exp_busy = 1'b0;
        for (int p = 0; p < P; p++) begin
            for (int f = 0; f < 8; f++)
                raw[f] = bus.joy_flat[16*p + joybit[f]] | (kb[p][f] != 0);
            // Directions as a clockwise ring U,R,D,L; rotating by k steps.
            cw[0] = raw[0]; cw[1] = raw[3]; cw[2] = raw[1]; cw[3] = raw[2];
            for (int i = 0; i < 4; i++) rd[i] = cw[(i - int'(bus.rotate) + 4) % 4];
            o[0] = rd[0]; o[3] = rd[1]; o[1] = rd[2]; o[2] = rd[3];
`ifdef ARCADE_INPUT_SOCD_EN
            if (o[0] && o[1]) begin o[0] = 1'b0; o[1] = 1'b0; end
            if (o[2] && o[3]) begin o[2] = 1'b0; o[3] = 1'b0; end
`endif
            if (bus.autofire_en && raw[4]) begin
                o[4] = ((af_ticks[p] / AF_DIV) % 2) == 0;
                if (bus.ce) af_ticks[p]++;
            end else begin
                o[4] = raw[4];
                af_ticks[p] = 0;
            end
            o[5] = raw[5];
            o[6] = raw[6];
            if (m_primed && raw[7] && !coin_prev[p] && coin_rem[p] == 0)
                coin_rem[p] = COIN_PULSE;
            else if (bus.ce && coin_rem[p] > 0)
                coin_rem[p]--;
            coin_prev[p] = raw[7];
            o[7] = coin_rem[p] > 0;
            if (o[7]) exp_busy = 1'b1;
            for (int f = 0; f < 8; f++) byte_v[f] = (ACTIVE_LOW != 0) ? ~o[f] : o[f];
            exp_pout[8*p +: 8] = byte_v;
        end
        m_primed = 1'b1;
    endtask

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
            if (RESET) model_reset();
            else model_step();
            chk("p_out", bus.p_out, exp_pout);
            chk("coin_busy", bus.coin_busy, exp_busy);
        end
    endtask

    task automatic ps2_evt(input logic [8:0] code, input logic pr);
        bus.ps2_key = {~bus.ps2_key[10], pr, code};
    endtask

    logic [8:0] keys [12] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h029, 9'h014,
                              9'h011, 9'h005, 9'h02E, 9'h006, 9'h036, 9'h075};
    int low_cnt;
    int b;

    initial begin
        model_reset();
        bus.ce          = 1'b1;
        bus.ps2_key     = '0;
        bus.joy_flat    = '1;
        bus.rotate      = 2'd0;
        bus.autofire_en = 1'b0;

        // Reset with everything pressed, stale toggle with a coin key pending.
        cycle(3);
        chk("rst_pout", bus.p_out, 16'hFFFF);
        chk("rst_busy", bus.coin_busy, 0);
        bus.joy_flat = '0;
        bus.ps2_key  = {1'b1, 1'b1, 9'h02E};
        RESET = 1'b0;
        cycle(3);
        chk("idle_after_rst", bus.p_out, 16'hFFFF);

        // Rotation of a single left input.
        bus.joy_flat[1] = 1'b1;
        bus.rotate = 2'd1;
        cycle(1);
        chk("rot1_up", bus.p_out[0], 0);
        bus.rotate = 2'd3;
        cycle(1);
        chk("rot3_down", bus.p_out[1], 0);
        chk("rot3_up_idle", bus.p_out[0], 1);
        bus.joy_flat = '0;
        bus.rotate = 2'd0;
        cycle(2);

        // Non-extended 0x75 is not an arrow; F2 is player 1 start.
        ps2_evt(9'h075, 1'b1);
        cycle(1);
        chk("nonext_ignored", bus.p_out[0], 1);
        ps2_evt(9'h006, 1'b1);
        cycle(1);
        chk("p1_start", bus.p_out[14], 0);
        ps2_evt(9'h006, 1'b0);
        cycle(1);
        chk("p1_start_rel", bus.p_out[14], 1);

        // Keyboard coin: one pulse, no extension, re-arm after release.
        ps2_evt(9'h02E, 1'b1);
        low_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 5) ps2_evt(9'h02E, 1'b1);
            cycle(1);
            if (bus.p_out[7] == 1'b0) low_cnt++;
        end
        chk("coin_width_kbd", low_cnt, 16);
        ps2_evt(9'h02E, 1'b0);
        cycle(3);
        chk("coin_idle", bus.p_out[7], 1);
        ps2_evt(9'h02E, 1'b1);
        low_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(1);
            if (bus.p_out[7] == 1'b0) low_cnt++;
        end
        chk("coin_width_again", low_cnt, 16);
        ps2_evt(9'h02E, 1'b0);
        cycle(2);

        // Autofire square wave on fire1.
        bus.autofire_en = 1'b1;
        bus.joy_flat[4] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle(1);
            chk("af_wave", bus.p_out[4], ((i / 4) % 2 == 1) ? 1 : 0);
        end
        bus.joy_flat[4] = 1'b0;
        cycle(1);
        chk("af_release", bus.p_out[4], 1);
        bus.autofire_en = 1'b0;
        cycle(1);

        // Asynchronous reset mid-pulse with the coin request held throughout.
        bus.joy_flat[6] = 1'b1;
        cycle(5);
        #2 RESET = 1'b1;
        #1;
        chk("async_rst_pout", bus.p_out, 16'hFFFF);
        chk("async_rst_busy", bus.coin_busy, 0);
        model_reset();
        cycle(2);
        RESET = 1'b0;
        low_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1);
            if (bus.p_out[7] == 1'b0) low_cnt++;
        end
        chk("held_coin_no_pulse", low_cnt, 0);
        bus.joy_flat[6] = 1'b0;
        cycle(2);
        bus.joy_flat[6] = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1);
            if (bus.p_out[7] == 1'b0) low_cnt++;
        end
        chk("coin_after_rearm", low_cnt, 16);
        bus.joy_flat = '0;
        cycle(2);

        // Opposing directions: up+down+right.
        bus.joy_flat[3] = 1'b1;
        bus.joy_flat[2] = 1'b1;
        bus.joy_flat[0] = 1'b1;
        cycle(1);
`ifdef ARCADE_INPUT_SOCD_EN
        chk("socd_dirs", bus.p_out[3:0], 4'b0111);
`else
        chk("socd_dirs", bus.p_out[3:0], 4'b0100);
`endif
        bus.joy_flat = '0;
        cycle(2);

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            bus.ce = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) begin
                b = $urandom_range(0, 31);
                bus.joy_flat[b] = ~bus.joy_flat[b];
            end
            if ($urandom_range(0, 31) == 0) bus.rotate = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) bus.autofire_en = ~bus.autofire_en;
            if ($urandom_range(0, 9) == 0)
                ps2_evt(keys[$urandom_range(0, 11)], 1'($urandom_range(0, 1)));
            cycle(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
